// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: accepts a word via ready/load and
// emits it one bit per enabled edge with valid and last-bit qualifiers.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             en,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_q;
    logic               r_q_valid;
    logic               r_last;
    logic               r_busy;

    logic               w_ready;
    logic               w_accept;
    logic               w_first_bit;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_sr_shift;

    // A new word can be taken in IDLE, or as the final bit leaves on an enabled edge.
    assign w_ready  = (r_state == S_IDLE) ||
                      ((r_state == S_SHIFT) && (r_cnt == '0) && en);
    assign w_accept = load && w_ready;

    // The output end of the shift register is bit WIDTH-1 (MSB first) or bit 0.
    always_comb begin
        w_first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
        w_sr_shift  = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
        w_next_bit  = MSB_FIRST ? r_sr[WIDTH-2] : r_sr[1];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_q       <= 1'b0;
            r_q_valid <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
        end else if (w_accept) begin
            r_state   <= S_SHIFT;
            r_sr      <= din;
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_q       <= w_first_bit;
            r_q_valid <= 1'b1;
            r_last    <= 1'b0;
            r_busy    <= 1'b1;
        end else if ((r_state == S_SHIFT) && en) begin
            if (r_cnt != '0) begin
                r_sr   <= w_sr_shift;
                r_q    <= w_next_bit;
                r_cnt  <= r_cnt - CNT_W'(1);
                r_last <= (r_cnt == CNT_W'(1));
            end else begin
                r_state   <= S_IDLE;
                r_q       <= 1'b0;
                r_q_valid <= 1'b0;
                r_last    <= 1'b0;
                r_busy    <= 1'b0;
            end
        end
    end

    assign ready   = w_ready;
    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign last    = r_last;
    assign busy    = r_busy;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: MSB-first and LSB-first instances,
// per-cycle expected {q,last} queued at stimulus time and popped on q_valid.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic [3:0] din_m, din_l;
    logic       load_m, load_l;
    logic       ready_m, q_m, qv_m, last_m, busy_m;
    logic       ready_l, q_l, qv_l, last_l, busy_l;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0] exp_m[$];
    logic [1:0] exp_l[$];

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clr(clr), .din(din_m), .load(load_m), .en(en),
        .ready(ready_m), .q(q_m), .q_valid(qv_m), .last(last_m), .busy(busy_m)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clr(clr), .din(din_l), .load(load_l), .en(en),
        .ready(ready_l), .q(q_l), .q_valid(qv_l), .last(last_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances against their scoreboards for the current cycle.
    task automatic monitor();
        logic [1:0] e;
        logic       want_m, want_l;
        want_m = (exp_m.size() != 0);
        want_l = (exp_l.size() != 0);
        chk("m_q_valid", {3'b0, qv_m}, {3'b0, want_m});
        chk("m_busy",    {3'b0, busy_m}, {3'b0, want_m});
        if (qv_m && want_m) begin
            e = exp_m.pop_front();
            chk("m_q_last", {2'b0, q_m, last_m}, {2'b0, e});
        end else if (!qv_m) begin
            chk("m_idle_q_last", {2'b0, q_m, last_m}, 4'h0);
        end
        chk("l_q_valid", {3'b0, qv_l}, {3'b0, want_l});
        chk("l_busy",    {3'b0, busy_l}, {3'b0, want_l});
        if (qv_l && want_l) begin
            e = exp_l.pop_front();
            chk("l_q_last", {2'b0, q_l, last_l}, {2'b0, e});
        end else if (!qv_l) begin
            chk("l_idle_q_last", {2'b0, q_l, last_l}, 4'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    // Queue one word for the MSB instance with en held high.
    task automatic push_m(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) exp_m.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
    endtask

    initial begin
        clr    = 1'b0;
        en     = 1'b1;
        din_m  = 4'h0;
        din_l  = 4'h0;
        load_m = 1'b0;
        load_l = 1'b0;
        #1;
        // Reset state
        chk("rst_ready_m", {3'b0, ready_m}, 4'h1);
        chk("rst_ready_l", {3'b0, ready_l}, 4'h1);
        monitor();
        tick();
        tick();
        clr = 1'b1;
        tick();

        // Single word MSB first: 1011
        din_m  = 4'b1011;
        load_m = 1'b1;
        push_m(4'b1011);
        tick();
        load_m = 1'b0;
        chk("single_ready_busy", {3'b0, ready_m}, 4'h0);
        tick();
        tick();
        tick();
        chk("single_ready_final", {3'b0, ready_m}, 4'h1);
        tick();
        chk("single_drained", 4'(exp_m.size()), 4'h0);

        // Back-to-back: 1011 then 0110 with load held
        din_m  = 4'b1011;
        load_m = 1'b1;
        push_m(4'b1011);
        push_m(4'b0110);
        tick();
        din_m = 4'b0110;
        for (int i = 0; i < 3; i++) tick();
        tick();
        load_m = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("b2b_drained", 4'(exp_m.size()), 4'h0);

        // Stall: en toggles during 1100, each bit held two cycles
        din_m  = 4'b1100;
        load_m = 1'b1;
        en     = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic [3:0] w;
            w = 4'b1100;
            exp_m.push_back({w[3 - (k - 1) / 2], (k >= 7) ? 1'b1 : 1'b0});
        end
        tick();
        load_m = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            en = (k % 2 == 0);
            #1;
            chk("stall_ready", {3'b0, ready_m}, {3'b0, (k >= 7) && en});
            tick();
        end
        chk("stall_drained", 4'(exp_m.size()), 4'h0);
        en = 1'b1;

        // LSB first: 0001, load held and din changed mid-word are ignored
        din_l  = 4'b0001;
        load_l = 1'b1;
        exp_l.push_back(2'b10);
        exp_l.push_back(2'b00);
        exp_l.push_back(2'b00);
        exp_l.push_back(2'b01);
        tick();
        din_l = 4'b1111;
        #1;
        chk("lsb_ready_busy", {3'b0, ready_l}, 4'h0);
        tick();
        tick();
        load_l = 1'b0;
        tick();
        tick();
        chk("lsb_drained", 4'(exp_l.size()), 4'h0);

        // Reset mid-word: 1010, clear after second bit, then clean 0101
        din_m  = 4'b1010;
        load_m = 1'b1;
        push_m(4'b1010);
        tick();
        load_m = 1'b0;
        tick();
        clr = 1'b0;
        exp_m.delete();
        #1;
        chk("midrst_ready", {3'b0, ready_m}, 4'h1);
        chk("midrst_outs", {q_m, qv_m, last_m, busy_m}, 4'h0);
        tick();
        clr = 1'b1;
        tick();
        din_m  = 4'b0101;
        load_m = 1'b1;
        push_m(4'b0101);
        tick();
        load_m = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_drained", 4'(exp_m.size()), 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
